count_sched: RTL and testbench



---
 rtl/count_sched_pkg.sv | 32 +++
 rtl/count_sched_rr_arbiter.sv | 26 ++
 rtl/count_sched.sv | 87 ++++++++
 tb/tb_count_sched.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/count_sched_pkg.sv
// rtl/count_sched_pkg.sv - shared types, defaults and round-robin pick helper for count_sched
package count_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int unsigned DEF_NUM_REQ     = 4;
  localparam int unsigned DEF_INPUT_WIDTH = 8;
  localparam int unsigned MAX_REQ         = 32;
  localparam int unsigned MAX_ID_W        = 5;

  // First valid requester at or after ptr, wrapping at n-1 -> 0; result is one-hot or zero.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                 input int unsigned n,
                                                 input int unsigned ptr);
    logic [MAX_REQ-1:0] gnt;
    int unsigned        idx;
    gnt = '0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      if (k < n) begin
        idx = ptr + k;
        if (idx >= n) idx = idx - n;
        if (valid[idx[MAX_ID_W-1:0]] && (gnt == '0)) gnt[idx[MAX_ID_W-1:0]] = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/count_sched_rr_arbiter.sv
// rtl/count_sched_rr_arbiter.sv - combinational round-robin arbiter, pointer held by the caller
module rr_arbiter
  import count_sched_pkg::*;
#(
  parameter int unsigned N  = DEF_NUM_REQ,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_id
);

  logic [MAX_REQ-1:0] pick;

  always_comb begin
    pick   = rr_pick(MAX_REQ'(req), N, 32'(ptr));
    gnt    = en ? pick[N-1:0] : '0;
    gnt_id = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (pick[i]) gnt_id = IW'(i);
    end
  end

endmodule

// File: rtl/count_sched.sv
// rtl/count_sched.sv - round-robin scheduler sharing one up-counter among NUM_REQ requesters
module count_sched
  import count_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ     = DEF_NUM_REQ,
  parameter int unsigned INPUT_WIDTH = DEF_INPUT_WIDTH,
  parameter int unsigned ID_W        = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*INPUT_WIDTH-1:0] req_stop,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             resp_valid,
  output logic                           busy,
  output logic [ID_W-1:0]                cur_id,
  output logic [INPUT_WIDTH-1:0]         cur_count
);

  state_e                 state_q, state_d;
  logic [INPUT_WIDTH-1:0] ctr_q, ctr_d;
  logic [INPUT_WIDTH-1:0] stop_q, stop_d;
  logic [ID_W-1:0]        cur_id_q, cur_id_d;
  logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]     gnt;
  logic [ID_W-1:0]        gnt_id;

  rr_arbiter #(.N(NUM_REQ), .IW(ID_W)) u_arb (
    .req    (req_valid),
    .ptr    (rr_ptr_q),
    .en     ((state_q == IDLE) && !reset),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  always_comb begin
    state_d    = state_q;
    ctr_d      = ctr_q;
    stop_d     = stop_q;
    cur_id_d   = cur_id_q;
    rr_ptr_d   = rr_ptr_q;
    resp_valid = '0;
    case (state_q)
      IDLE: begin
        if (gnt != '0) begin
          stop_d   = req_stop[gnt_id*INPUT_WIDTH +: INPUT_WIDTH];
          cur_id_d = gnt_id;
          ctr_d    = '0;
          // Explicit wrap so non-power-of-2 NUM_REQ never points past the last requester.
          rr_ptr_d = (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;
          state_d  = COUNT;
        end
      end
      COUNT: begin
        if (ctr_q == stop_q) state_d = DONE;
        else                 ctr_d   = ctr_q + 1'b1;
      end
      DONE: begin
        if (!reset) resp_valid[cur_id_q] = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ctr_q    <= '0;
      stop_q   <= '0;
      cur_id_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      ctr_q    <= ctr_d;
      stop_q   <= stop_d;
      cur_id_q <= cur_id_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign req_ready = gnt;
  assign busy      = (state_q != IDLE);
  assign cur_id    = cur_id_q;
  assign cur_count = ctr_q;

endmodule

// File: tb/tb_count_sched.sv
// tb/tb_count_sched.sv - scoreboard bench for count_sched
module tb_count_sched;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_stop;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   resp_valid;
  logic           busy;
  logic [1:0]     cur_id;
  logic [W-1:0]   cur_count;

  typedef struct {
    int id;
    int due;
    int stop;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  count_sched #(.NUM_REQ(N), .INPUT_WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_stop   (req_stop),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .busy       (busy),
    .cur_id     (cur_id),
    .cur_count  (cur_count)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Handshakes push the expected completion; completions pop and compare.
  always @(negedge clk) begin
    if (!reset) begin
      if (req_ready != '0) check("ready_onehot", $countones(req_ready), 1);
      for (int g = 0; g < N; g++) begin
        if (req_valid[g] && req_ready[g])
          sb.push_back('{g, cyc + int'(req_stop[g*W +: W]) + 2, int'(req_stop[g*W +: W])});
      end
      if (resp_valid != '0) begin
        if (sb.size() == 0) begin
          check("resp_unexpected", int'(resp_valid), 0);
        end else begin
          e = sb.pop_front();
          check("resp_onehot", int'(resp_valid), 1 << e.id);
          check("resp_latency", cyc, e.due);
          check("resp_count", int'(cur_count), e.stop);
        end
      end else if (sb.size() != 0 && cyc > sb[0].due) begin
        check("resp_missing", 0, 1);
        void'(sb.pop_front());
      end
    end
  end

  task automatic wait_idle();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (busy && k < 1000);
    check("idle", int'(busy), 0);
  endtask

  task automatic req_and_grant(input int g, input int stop, input string tag);
    int k = 0;
    @(posedge clk);
    #1;
    req_stop[g*W +: W] = stop[W-1:0];
    req_valid[g] = 1'b1;
    do begin
      @(negedge clk);
      k++;
    end while (!req_ready[g] && k < 600);
    check(tag, int'(req_ready[g]), 1);
    @(posedge clk);
    #1;
    req_valid[g] = 1'b0;
  endtask

  int order[$];
  int hs[$];
  int id;
  int k;

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_stop  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", int'(req_ready), 0);
    check("rst_resp", int'(resp_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_count", int'(cur_count), 0);
    check("rst_id", int'(cur_id), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // single job, stop=3
    req_stop[0 +: W] = 8'd3;
    req_valid[0] = 1'b1;
    @(negedge clk);
    check("t1_ready", int'(req_ready), 1);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("t1_count", int'(cur_count), c);
      check("t1_busy", int'(busy), 1);
    end
    wait_idle();

    // stop=0 on requester 2
    req_and_grant(2, 0, "t2_grant");
    @(negedge clk);
    check("t2_count", int'(cur_count), 0);
    check("t2_id", int'(cur_id), 2);
    wait_idle();
    check("t2_count_idle", int'(cur_count), 0);

    // all four valid from rr_ptr=0
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int g = 0; g < N; g++) req_stop[g*W +: W] = W'(g + 1);
    req_valid = '1;
    k = 0;
    while (order.size() < 4 && k < 100) begin
      @(negedge clk);
      k++;
      if ((req_valid & req_ready) != '0) begin
        id = 0;
        for (int g = 0; g < N; g++) if (req_valid[g] && req_ready[g]) id = g;
        order.push_back(id);
        hs.push_back(cyc);
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
      end
    end
    check("t3_njobs", order.size(), 4);
    for (int i = 0; i < order.size(); i++) check("t3_order", order[i], i);
    for (int i = 1; i < hs.size(); i++) check("t3_period", hs[i] - hs[i-1], i + 3);
    wait_idle();

    // fairness: 0 re-asserts while 3 waits with rr_ptr=1
    req_and_grant(0, 2, "t4_grant0");
    req_stop[3*W +: W] = 8'd1;
    req_valid[3] = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!resp_valid[0] && k < 50);
    check("t4_resp0", int'(resp_valid[0]), 1);
    @(posedge clk);
    #1;
    req_stop[0 +: W] = 8'd1;
    req_valid[0] = 1'b1;
    @(negedge clk);
    check("t4_fair", int'(req_ready), 8);
    @(posedge clk);
    #1;
    req_valid[3] = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!req_ready[0] && k < 50);
    check("t4_then0", int'(req_ready[0]), 1);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    wait_idle();

    // reset mid-job
    req_and_grant(1, 10, "t5_grant");
    k = 0;
    while (cur_count != 8'd5 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("t5_reach5", int'(cur_count), 5);
    reset = 1'b1;
    @(negedge clk);
    check("t5_busy", int'(busy), 0);
    check("t5_count", int'(cur_count), 0);
    check("t5_resp", int'(resp_valid), 0);
    sb.delete();
    reset = 1'b0;
    repeat (15) @(negedge clk);

    // max stop value
    req_and_grant(2, 255, "t6_grant");
    wait_idle();
    check("t6_count_idle", int'(cur_count), 255);

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
